// File: rtl/nibble_add_seq_if.sv
// Operand/result handshake bundle plus the link to the external 4-bit adder slice.
interface nibble_add_seq_if #(
  parameter int NIBBLES = 4
) ();
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         op_sub;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_ci;
  logic [3:0]   add_s;
  logic         add_co;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         res_cout;
  logic         res_ovf;
  logic         busy;

  modport master (
    output in_valid, op_a, op_b, op_cin, op_sub, out_ready, add_s, add_co,
    input  in_ready, add_a, add_b, add_ci, out_valid, res, res_cout, res_ovf, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, op_cin, op_sub, out_ready, add_s, add_co,
    output in_ready, add_a, add_b, add_ci, out_valid, res, res_cout, res_ovf, busy
  );
endinterface

// File: rtl/nibble_add_seq.sv
// Sequential W-bit add/subtract that reuses one external 4-bit adder slice,
// walking the operands LSB nibble first and rippling the carry through a register.
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  nibble_add_seq_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  a_sh_s;
  logic [W-1:0]  b_sh_s;
  logic [3:0]    add_a_s;
  logic [3:0]    add_b_s;
  logic          add_ci_s;

  assign a_sh_s = a_q >> {idx_q, 2'b00};
  assign b_sh_s = b_q >> {idx_q, 2'b00};

  // Next-state and datapath update; B is stored already inverted for subtract.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.op_a;
          b_d     = bus.op_sub ? ~bus.op_b : bus.op_b;
          carry_d = bus.op_sub ? 1'b1 : bus.op_cin;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        res_d[{idx_q, 2'b00} +: 4] = bus.add_s;
        carry_d = bus.add_co;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          cout_d  = bus.add_co;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (bus.add_s[3] != a_q[W-1]);
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Adder slice is only fed while stepping through nibbles.
  always_comb begin
    if (state_q == S_RUN) begin
      add_a_s  = a_sh_s[3:0];
      add_b_s  = b_sh_s[3:0];
      add_ci_s = carry_q;
    end else begin
      add_a_s  = 4'h0;
      add_b_s  = 4'h0;
      add_ci_s = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.add_a     = add_a_s;
  assign bus.add_b     = add_b_s;
  assign bus.add_ci    = add_ci_s;
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.res       = res_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_ovf   = ovf_q;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq (NIBBLES=4) with a behavioural adder slice
// and a queue-based scoreboard checked by an independent output monitor.
module tb_nibble_add_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        o;
  } exp_t;
  exp_t sbq[$];

  nibble_add_seq_if #(.NIBBLES(4)) bus ();
  nibble_add_seq #(.NIBBLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // behavioural 4-bit adder slice
  assign {bus.add_co, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0000, bus.add_ci};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor: compare every presented result against the scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("res", {16'h0, bus.res}, {16'h0, e.r});
        check("res_cout", {31'h0, bus.res_cout}, {31'h0, e.c});
        check("res_ovf", {31'h0, bus.res_ovf}, {31'h0, e.o});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input logic [15:0] er, input logic ec,
                        input logic eo, input bit stall);
    wait_ready();
    bus.out_ready = stall ? 1'b0 : 1'b1;
    bus.op_a = a; bus.op_b = b; bus.op_cin = cin; bus.op_sub = sub;
    bus.in_valid = 1'b1;
    sbq.push_back('{r: er, c: ec, o: eo});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check("out_valid_latency", {31'h0, bus.out_valid}, (k == 4) ? 32'd1 : 32'd0);
      if (stall && k == 1) begin
        bus.op_a = 16'hAAAA; bus.op_b = 16'h5555; bus.in_valid = 1'b1;
      end else if (stall && k == 2) begin
        bus.in_valid = 1'b0;
      end
    end
    if (stall) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk);
        #1 bus.in_valid = 1'b1;
        @(negedge clk);
        check("stall_out_valid", {31'h0, bus.out_valid}, 32'd1);
        check("stall_res", {16'h0, bus.res}, {16'h0, er});
        check("stall_in_ready", {31'h0, bus.in_ready}, 32'd0);
      end
      @(posedge clk);
      #1 begin bus.in_valid = 1'b0; bus.out_ready = 1'b1; end
      @(negedge clk);
      check("in_ready_before_hs", {31'h0, bus.in_ready}, 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_hs", {31'h0, bus.in_ready}, 32'd1);
    check("out_valid_after_hs", {31'h0, bus.out_valid}, 32'd0);
    check("res_held_after_hs", {16'h0, bus.res}, {16'h0, er});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.op_a = 16'h0; bus.op_b = 16'h0;
    bus.op_cin = 1'b0; bus.op_sub = 1'b0; bus.out_ready = 1'b1;
    #2;
    check("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    check("rst_busy", {31'h0, bus.busy}, 32'd0);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check("rst_res", {16'h0, bus.res}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op(16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    run_op(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

    // abort an operation mid-flight with reset
    wait_ready();
    bus.op_a = 16'h1234; bus.op_b = 16'h4321; bus.op_cin = 1'b0; bus.op_sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_res", {16'h0, bus.res}, 32'd0);
    check("mid_rst_cout", {30'h0, bus.res_cout, bus.res_ovf}, 32'd0);
    check("mid_rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check("mid_rst_busy", {31'h0, bus.busy}, 32'd0);
    check("mid_rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    check("mid_rst_add", {23'h0, bus.add_a, bus.add_b, bus.add_ci}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
